frame_capture_writer: RTL and testbench

- Write side of the 12-bit frame buffer that VGA_Controller reads through frame_addr/frame_pixel.
- Accepts a camera-style byte stream (vsync, href, 8-bit data, byte strobe), pairs bytes into RGB565 and reduces them to RGB444.
- Optionally decimates 2:1 in both directions, then issues linear write address, data and write-enable to the buffer's port A.
- Runs on clk25 beside image_processing; one whole frame is written per arm.

---
 rtl/capture_pkg.sv | 18 +
 rtl/edge_detect.sv | 21 ++
 rtl/frame_capture_writer.sv | 156 +++++++++++++++
 tb/tb_frame_capture_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the camera frame-capture write path.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } cap_state_e;

  localparam int FRAME_PIXELS_DEFAULT = 19200;

  // Keep the top bits of each RGB565 channel: {R[4:1], G[5:2], B[4:1]}.
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered-history edge detector: compares the live input against its
// value on the previous clk edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/frame_capture_writer.sv
// Camera byte stream -> RGB444 frame buffer writer, one frame per arm.
//   state  | meaning
//   IDLE   | disarmed, waiting for enable
//   SYNC   | armed, waiting for vsync to fall; counters held clear
//   ACTIVE | pairing bytes and writing pixels
//   DONE   | one-cycle frame_done, then back to IDLE
module frame_capture_writer
  import capture_pkg::*;
#(
  parameter int SRC_W        = 320,
  parameter int SRC_H        = 240,
  parameter int DECIM        = 1,
  parameter int ADDR_W       = 16,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_vld,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] capture_addr,
  output logic [11:0]       capture_data,
  output logic              capture_we,
  output logic              busy,
  output logic              frame_done
);

  localparam int X_W   = $clog2(SRC_W);
  localparam int Y_W   = $clog2(SRC_H);
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

  cap_state_e        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              we_q, we_d;

  logic vs_rise, vs_fall, href_fall, href_rise_unused;
  logic full, byte_ok, keep, store;

  edge_detect u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (cam_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  edge_detect u_href_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (cam_href),
    .rise_o (href_rise_unused),
    .fall_o (href_fall)
  );

  assign full    = (wcnt_q == CNT_W'(FRAME_PIXELS));
  assign byte_ok = (state_q == ACTIVE) && cam_byte_vld && cam_href;
  assign keep    = (DECIM == 0) || (!x_q[0] && !y_q[0]);
  assign store   = byte_ok && phase_q && keep && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = SYNC;
      SYNC:    if (vs_fall) state_d = ACTIVE;
      ACTIVE:  if (vs_rise || full) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      SYNC, ACTIVE: busy = 1'b1;
      DONE:         frame_done = 1'b1;
      default:      ;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    if (state_q == SYNC) begin
      x_d     = '0;
      y_d     = '0;
      phase_d = 1'b0;
      wcnt_d  = '0;
      addr_d  = '0;
    end else if (state_q == ACTIVE) begin
      // href low on its falling edge, so a byte in that cycle never reaches byte_ok
      if (href_fall) begin
        x_d     = '0;
        phase_d = 1'b0;
        if (y_q != '1) y_d = y_q + 1'b1;
      end
      if (byte_ok) begin
        phase_d = ~phase_q;
        if (!phase_q)      hi_d = cam_data;
        else if (x_q != '1) x_d = x_q + 1'b1;
      end
      if (store) begin
        we_d   = 1'b1;
        data_d = rgb565_to_444({hi_q, cam_data});
        addr_d = ADDR_W'(wcnt_q);
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign capture_addr = addr_q;
  assign capture_data = data_q;
  assign capture_we   = we_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench for frame_capture_writer: three configurations share one
// camera stream; a pixel-level scoreboard predicts every write and pulse.
module tb_frame_capture_writer;

  logic clk = 1'b0;
  logic rst, enable, cam_vsync, cam_href, cam_byte_vld;
  logic [7:0] cam_data;

  logic [15:0] addr_w [3];
  logic [11:0] data_w [3];
  logic        we_w   [3];
  logic        busy_w [3];
  logic        done_w [3];

  int dec_k [3] = '{0, 1, 0};
  int fp_k  [3] = '{19200, 19200, 6};

  frame_capture_writer #(.SRC_W(320), .SRC_H(240), .DECIM(0), .ADDR_W(16), .FRAME_PIXELS(19200)) u_full (
    .clk(clk), .rst(rst), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_byte_vld(cam_byte_vld), .cam_data(cam_data), .capture_addr(addr_w[0]),
    .capture_data(data_w[0]), .capture_we(we_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

  frame_capture_writer #(.SRC_W(320), .SRC_H(240), .DECIM(1), .ADDR_W(16), .FRAME_PIXELS(19200)) u_decim (
    .clk(clk), .rst(rst), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_byte_vld(cam_byte_vld), .cam_data(cam_data), .capture_addr(addr_w[1]),
    .capture_data(data_w[1]), .capture_we(we_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

  frame_capture_writer #(.SRC_W(320), .SRC_H(240), .DECIM(0), .ADDR_W(16), .FRAME_PIXELS(6)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_byte_vld(cam_byte_vld), .cam_data(cam_data), .capture_addr(addr_w[2]),
    .capture_data(data_w[2]), .capture_we(we_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_cyc [3][256];
  int exp_addr[3][256];
  int exp_data[3][256];
  int wp[3] = '{0, 0, 0};
  int rp[3] = '{0, 0, 0};
  int log_addr[3][256];
  int log_data[3][256];
  int log_cyc [3][256];
  int nlog[3] = '{0, 0, 0};
  int done_cnt[3] = '{0, 0, 0};
  int done_cyc[3] = '{0, 0, 0};
  int cnt_f[3];
  int n0[3];
  int d0[3];
  int vs_cyc;
  bit armed;
  bit killed;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int exp444(input int hi, input int lo);
    int r, g, b;
    r = hi >> 3;
    g = ((hi & 7) << 3) | (lo >> 5);
    b = lo & 31;
    return ((r >> 1) << 8) | ((g >> 2) << 4) | (b >> 1);
  endfunction

  function automatic logic [7:0] byte_of(input int pat, input int l, input int b, input int npx);
    int v;
    v = l * npx + b / 2;
    case (pat)
      0:       return (b % 2 == 0) ? 8'hF8 : 8'h00;
      1:       return (b % 2 == 0) ? 8'(v >> 8) : 8'(v & 255);
      default: return (b % 2 == 0) ? 8'h12 : 8'h34;
    endcase
  endfunction

  // Compare point, once per cycle on the falling edge.
  task automatic sample();
    for (int k = 0; k < 3; k++) begin
      if (we_w[k]) begin
        if (rp[k] == wp[k]) begin
          check($sformatf("spurious_we_%0d", k), int'(we_w[k]), 0);
        end else begin
          check($sformatf("we_cycle_%0d", k), cyc, exp_cyc[k][rp[k]]);
          check($sformatf("addr_%0d", k), int'(addr_w[k]), exp_addr[k][rp[k]]);
          check($sformatf("data_%0d", k), int'(data_w[k]), exp_data[k][rp[k]]);
          rp[k]++;
        end
        log_addr[k][nlog[k]] = int'(addr_w[k]);
        log_data[k][nlog[k]] = int'(data_w[k]);
        log_cyc[k][nlog[k]]  = cyc;
        nlog[k]++;
      end
      if (done_w[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
        check($sformatf("busy_at_done_%0d", k), int'(busy_w[k]), 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Second byte of pixel p on line l arrives this cycle; the write is due next cycle.
  task automatic model_pixel(input int l, input int p, input int hi, input int lo);
    for (int k = 0; k < 3; k++) begin
      if (armed && !killed && cnt_f[k] < fp_k[k] &&
          (dec_k[k] == 0 || (p % 2 == 0 && l % 2 == 0))) begin
        exp_cyc[k][wp[k]]  = cyc + 1;
        exp_addr[k][wp[k]] = cnt_f[k];
        exp_data[k][wp[k]] = exp444(hi, lo);
        wp[k]++;
        cnt_f[k]++;
      end
    end
  endtask

  task automatic do_reset();
    check("we_before_rst", int'(we_w[0]), 1);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_we_%0d", k), int'(we_w[k]), 0);
      check($sformatf("rst_busy_%0d", k), int'(busy_w[k]), 0);
      check($sformatf("rst_done_%0d", k), int'(done_w[k]), 0);
      if (wp[k] > rp[k] && exp_cyc[k][wp[k]-1] == cyc) wp[k]--;
    end
    killed = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send_frame(input int nlines, input int nbytes, input int odd_line,
                            input int odd_bytes, input int pat, input int drop_en_after,
                            input int rst_line);
    int nb;
    int hi;
    for (int k = 0; k < 3; k++) begin
      cnt_f[k] = 0;
      n0[k] = nlog[k];
      d0[k] = done_cnt[k];
    end
    killed = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < nlines; l++) begin
      nb = (l == odd_line) ? odd_bytes : nbytes;
      cam_href = 1'b1;
      tick();
      hi = 0;
      for (int b = 0; b < nb; b++) begin
        cam_byte_vld = 1'b1;
        cam_data = byte_of(pat, l, b, nbytes / 2);
        if (b % 2 == 0) hi = int'(cam_data);
        else            model_pixel(l, b / 2, hi, int'(cam_data));
        tick();
        cam_byte_vld = 1'b0;
        if (l == rst_line && b == 3) do_reset();
        tick();
      end
      cam_href = 1'b0;
      if (l == odd_line) begin
        cam_byte_vld = 1'b1;
        cam_data = byte_of(pat, l, nb, nbytes / 2);
      end
      tick();
      cam_byte_vld = 1'b1;
      cam_data = 8'h55;
      tick();
      cam_byte_vld = 1'b0;
      tick();
      tick();
      if (l == drop_en_after) enable = 1'b0;
    end
    tick();
    cam_vsync = 1'b1;
    vs_cyc = cyc;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("writes_drained_%0d", k), rp[k], wp[k]);
      check($sformatf("done_pulses_%0d", k), done_cnt[k] - d0[k], (armed && !killed) ? 1 : 0);
    end
  endtask

  int bexp[4] = '{0, 1, 4, 5};

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_byte_vld = 1'b0;
    cam_data = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_we_%0d", k), int'(we_w[k]), 0);
      check($sformatf("reset_busy_%0d", k), int'(busy_w[k]), 0);
      check($sformatf("reset_done_%0d", k), int'(done_w[k]), 0);
      check($sformatf("reset_addr_%0d", k), int'(addr_w[k]), 0);
      check($sformatf("reset_data_%0d", k), int'(data_w[k]), 0);
    end
    rst = 1'b1;
    enable = 1'b1;
    armed = 1'b1;

    // 4x2 red frame; the FRAME_PIXELS=6 instance saturates inside it.
    send_frame(2, 8, -1, 0, 0, -1, -1);
    check("f1_full_count", nlog[0] - n0[0], 8);
    check("f1_full_last_addr", log_addr[0][nlog[0]-1], 7);
    check("f1_full_last_data", log_data[0][nlog[0]-1], 12'hF00);
    check("f1_decim_count", nlog[1] - n0[1], 2);
    check("f1_sat_count", nlog[2] - n0[2], 6);
    check("f1_sat_last_addr", log_addr[2][nlog[2]-1], 5);
    check("f1_sat_done_after_write", int'(done_cyc[2] > log_cyc[2][nlog[2]-1]), 1);
    check("f1_sat_done_before_vsync", int'(done_cyc[2] < vs_cyc), 1);

    // 4x4 frame, pixel value = index; decimated instance keeps (0,0),(2,0),(0,2),(2,2).
    send_frame(4, 8, -1, 0, 1, -1, -1);
    check("f2_full_count", nlog[0] - n0[0], 16);
    check("f2_decim_count", nlog[1] - n0[1], 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f2_decim_addr%0d", i), log_addr[1][n0[1]+i], i);
      check($sformatf("f2_decim_data%0d", i), log_data[1][n0[1]+i], bexp[i]);
    end

    // Middle line has 5 bytes plus a strobe on the href falling cycle.
    send_frame(3, 8, 1, 5, 2, -1, -1);
    check("f3_full_count", nlog[0] - n0[0], 10);
    check("f3_full_last_data", log_data[0][nlog[0]-1], 12'h14A);
    check("f3_decim_count", nlog[1] - n0[1], 4);

    // enable drops after the first line: frame still completes, then no re-arm.
    send_frame(2, 8, -1, 0, 1, 0, -1);
    check("f4_full_count", nlog[0] - n0[0], 8);
    for (int k = 0; k < 3; k++) check($sformatf("f4_idle_busy_%0d", k), int'(busy_w[k]), 0);
    armed = 1'b0;
    send_frame(2, 8, -1, 0, 1, -1, -1);
    check("f5_full_count", nlog[0] - n0[0], 0);
    check("f5_decim_count", nlog[1] - n0[1], 0);

    // Reset mid-line, then the next frame restarts from address 0.
    enable = 1'b1;
    armed = 1'b1;
    send_frame(2, 8, -1, 0, 0, -1, 0);
    check("f6_full_count", nlog[0] - n0[0], 1);
    send_frame(2, 8, -1, 0, 1, -1, -1);
    check("f7_full_count", nlog[0] - n0[0], 8);
    check("f7_full_first_addr", log_addr[0][n0[0]], 0);
    check("f7_sat_count", nlog[2] - n0[2], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
